calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Operand/opcode entry controller that sits directly upstream of `alu_module` and downstream of it for result capture. It steps the user through entering operand A, an opcode and operand B from the 8 slide switches, one enter press per step. It drives the ALU's `sel`/`a`/`b` inputs, registers the ALU result, and presents the value to show on the display. The B step is skipped for unary ops, and a result can be chained as the next operand A.

## Interface
Parameters:
- `DATA_W`, 8: operand/result width; must match the ALU.
- `OP_W`, 4: opcode width; must match the ALU `sel`.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `sw_i`  in  DATA_W  switch value, already synchronous to `clk`.
- `enter_i`  in  1  debounced, synchronised enter button (level).
- `clear_i`  in  1  synchronous clear (level).
- `alu_sel_o`  out  OP_W  opcode to the ALU (registered).
- `alu_a_o`  out  DATA_W  operand A to the ALU (registered).
- `alu_b_o`  out  DATA_W  operand B to the ALU (registered).
- `alu_y_i`  in  DATA_W  combinational ALU result.
- `result_o`  out  DATA_W  registered result.
- `result_valid_o`  out  1  high while in S_SHOW.
- `err_div0_o`  out  1  last executed op was a divide by zero.
- `state_o`  out  3  current state: A=0, OP=1, B=2, EXEC=3, SHOW=4.
- `disp_o`  out  DATA_W  value for the display driver.

## Operation
- `enter_i` is reduced to a one-cycle press pulse `enter_p = enter_i & ~enter_q`, where `enter_q` is `enter_i` registered. A press held for any length gives exactly one step.
- State transitions:
  - **S_A**: on `enter_p`, set A ← `sw_i` and go to S_OP.
  - **S_OP**: on `enter_p`, set sel ← `sw_i[3:0]`.
    - Opcodes 12–15 are stored as 0 (NOP).
    - Unary opcodes (0–4) clear B to 0 and go to S_EXEC.
    - Other opcodes go to S_B.
  - **S_B**: on `enter_p`, set B ← `sw_i` and go to S_EXEC.
  - **S_EXEC**: lasts exactly one cycle with no input sampled; `enter_p` here is ignored.
    - Set result ← `alu_y_i`.
    - Set `err_div0_o` ← (sel==11 && B==0); in that case result is forced to 0x00.
    - Go to S_SHOW.
  - **S_SHOW**: on `enter_p`, set A ← result, clear `err_div0_o` and go to S_OP (chaining).
- `disp_o` is a combinational mux on the registered state:
  - S_A and S_B: `sw_i`.
  - S_OP: {4'b0, `sw_i[3:0]`}.
  - S_EXEC and S_SHOW: `result_o`.
- `result_o` holds its value through S_A, S_OP and S_B. It updates only in S_EXEC, or is cleared by clear/reset.
- All ALU arithmetic is 8-bit wrap-around; the block does not widen or saturate.
- `clear_i` forces the full reset state from any state, including mid-entry and S_EXEC. When `clear_i` and `enter_p` are both high, clear wins.

## Timing
- Reset and clear values: state S_A (`state_o`=0); A, B, sel, result all 0x00; `result_valid_o`=0; `err_div0_o`=0; `enter_q`=0.
  - Because `enter_q` resets to 0, an `enter_i` already high when reset releases counts as a press on the first cycle.
- Each capture occurs on the clock edge where `enter_i` is first sampled high.
- Latency from the edge that captures B (or sel, for unary ops):
  - The next cycle is S_EXEC.
  - `result_o`/`result_valid_o` are valid after the second edge.
- The ALU inputs are stable for the full S_EXEC cycle. The ALU path must close timing in one cycle, including multiply/divide.
- `result_valid_o` is registered and is deasserted on the edge that leaves S_SHOW.

## Structure
- Package `calc_pkg` holds:
  - the state enum `calc_state_t` (3-bit encoding as above);
  - opcode localparams `OP_NOP`=0, `OP_NOT`=1, `OP_SHL`=2, `OP_SHR`=3, `OP_INC`=4, `OP_AND`=5, `OP_OR`=6, `OP_XOR`=7, `OP_ADD`=8, `OP_SUB`=9, `OP_MUL`=10, `OP_DIV`=11;
  - function `is_unary(op)`.
- Sub-module `edge_pulse` (rising-edge detector, sync reset) generates `enter_p`.
- `alu_module` is instantiated alongside this block at the calculator top level, not inside it.

## Test plan
- **Binary op:** A=0x05, op=8, B=0x03 → S_EXEC then S_SHOW; `result_o`=0x08, `result_valid_o`=1 two edges after the B press.
- **Unary op skips B:** A=0x81, op=2 → state goes OP→EXEC with no S_B; result 0x02, `alu_b_o`=0x00.
- **Divide by zero:** A=0x10, op=11, B=0x00 → `result_o`=0x00, `err_div0_o`=1. The next press in S_SHOW clears the error.
- **Chaining:** after result 0x08, press in S_SHOW → S_OP with `alu_a_o`=0x08; then op=10, B=0x03 → result 0x18.
- **Held enter:** `enter_i` held high 20 cycles in S_A → exactly one advance, to S_OP.
- **Clear mid-entry:** clear asserted in S_B together with an enter press → next cycle is S_A with all registers 0x00 and `result_valid_o`=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and opcode constants for the calculator entry sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        StA    = 3'd0,
        StOp   = 3'd1,
        StB    = 3'd2,
        StExec = 3'd3,
        StShow = 3'd4
    } calc_state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_NOT = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_ADD = 4'd8;
    localparam logic [3:0] OP_SUB = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    function automatic logic is_unary(input logic [3:0] op);
        return op <= OP_INC;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of level_i.
module edge_pulse (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Steps the user through A / opcode / B entry, drives the external ALU and
// captures its result for display; results can be chained as the next A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_i,
    input  logic              enter_i,
    input  logic              clear_i,
    output logic [OP_W-1:0]   alu_sel_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_y_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              err_div0_o,
    output logic [2:0]        state_o,
    output logic [DATA_W-1:0] disp_o
);

    calc_state_t       state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [OP_W-1:0]   sel_q, sel_d;
    logic              valid_q, valid_d, err_q, err_d;
    logic              enter_p;
    logic [3:0]        op_in;
    logic              div0;

    // Clear also drops the edge history so a held button re-arms afterwards.
    edge_pulse u_enter_edge (
        .clk_i   (clk),
        .rst_i   (rst | clear_i),
        .level_i (enter_i),
        .pulse_o (enter_p)
    );

    // Opcodes above OP_DIV collapse to NOP.
    assign op_in = (sw_i[3:0] >= 4'd12) ? OP_NOP : sw_i[3:0];
    assign div0  = (sel_q == OP_W'(OP_DIV)) && (b_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StA;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        result_d = result_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (clear_i) begin
            state_d  = StA;
            a_d      = '0;
            b_d      = '0;
            sel_d    = '0;
            result_d = '0;
            valid_d  = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                StA: begin
                    if (enter_p) begin
                        a_d     = sw_i;
                        state_d = StOp;
                    end
                end
                StOp: begin
                    if (enter_p) begin
                        sel_d = OP_W'(op_in);
                        if (is_unary(op_in)) begin
                            b_d     = '0;
                            state_d = StExec;
                        end else begin
                            state_d = StB;
                        end
                    end
                end
                StB: begin
                    if (enter_p) begin
                        b_d     = sw_i;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    result_d = div0 ? '0 : alu_y_i;
                    err_d    = div0;
                    valid_d  = 1'b1;
                    state_d  = StShow;
                end
                StShow: begin
                    if (enter_p) begin
                        a_d     = result_q;
                        err_d   = 1'b0;
                        valid_d = 1'b0;
                        state_d = StOp;
                    end
                end
                default: state_d = StA;
            endcase
        end
    end

    always_comb begin
        disp_o = result_q;
        case (state_q)
            StA, StB: disp_o = sw_i;
            StOp:     disp_o = DATA_W'(sw_i[3:0]);
            default:  disp_o = result_q;
        endcase
    end

    assign alu_sel_o      = sel_q;
    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign err_div0_o     = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural ALU in the loop.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_i;
    logic       enter_i;
    logic       clear_i;
    logic [3:0] alu_sel_o;
    logic [7:0] alu_a_o, alu_b_o, alu_y;
    logic [7:0] result_o, disp_o;
    logic       result_valid_o, err_div0_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] op;
        logic [7:0] b;
        logic [3:0] exp_sel;
        logic [7:0] exp_y;
        logic       exp_err;
        logic       unary;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    calc_sequencer #(.DATA_W(8), .OP_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_i           (sw_i),
        .enter_i        (enter_i),
        .clear_i        (clear_i),
        .alu_sel_o      (alu_sel_o),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .alu_y_i        (alu_y),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .err_div0_o     (err_div0_o),
        .state_o        (state_o),
        .disp_o         (disp_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_y = alu_a_o;
        case (alu_sel_o)
            4'd1:    alu_y = ~alu_a_o;
            4'd2:    alu_y = alu_a_o << 1;
            4'd3:    alu_y = alu_a_o >> 1;
            4'd4:    alu_y = alu_a_o + 8'd1;
            4'd5:    alu_y = alu_a_o & alu_b_o;
            4'd6:    alu_y = alu_a_o | alu_b_o;
            4'd7:    alu_y = alu_a_o ^ alu_b_o;
            4'd8:    alu_y = alu_a_o + alu_b_o;
            4'd9:    alu_y = alu_a_o - alu_b_o;
            4'd10:   alu_y = alu_a_o * alu_b_o;
            4'd11:   alu_y = (alu_b_o == 8'd0) ? 8'hFF : alu_a_o / alu_b_o;
            default: alu_y = alu_a_o;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [7:0] v);
        sw_i    = v;
        enter_i = 1'b1;
        @(negedge clk);
        enter_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        enter_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_and_score(input string name);
        exp_t e;
        for (int i = 0; i < 8 && !result_valid_o; i++) @(negedge clk);
        check({name, "_valid"}, result_valid_o, 1);
        e = sb.pop_front();
        check({name, "_result"}, result_o, e.y);
        check({name, "_err"}, err_div0_o, e.err);
    endtask

    initial begin
        rst     = 1'b1;
        sw_i    = 8'h5A;
        enter_i = 1'b0;
        clear_i = 1'b0;

        vecs[0]  = '{8'h05, 4'd8,  8'h03, 4'd8,  8'h08, 1'b0, 1'b0};
        vecs[1]  = '{8'h81, 4'd2,  8'hAA, 4'd2,  8'h02, 1'b0, 1'b1};
        vecs[2]  = '{8'h10, 4'd11, 8'h00, 4'd11, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h03, 4'd9,  8'h05, 4'd9,  8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8'h20, 4'd10, 8'h10, 4'd10, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{8'h37, 4'd13, 8'hAA, 4'd0,  8'h37, 1'b0, 1'b1};
        vecs[6]  = '{8'hF0, 4'd7,  8'hFF, 4'd7,  8'h0F, 1'b0, 1'b0};
        vecs[7]  = '{8'h64, 4'd11, 8'h07, 4'd11, 8'h0E, 1'b0, 1'b0};
        vecs[8]  = '{8'h0F, 4'd1,  8'hAA, 4'd1,  8'hF0, 1'b0, 1'b1};
        vecs[9]  = '{8'hFF, 4'd4,  8'hAA, 4'd4,  8'h00, 1'b0, 1'b1};
        vecs[10] = '{8'h07, 4'd10, 8'h03, 4'd10, 8'h15, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_result", result_o, 0);
        check("rst_valid", result_valid_o, 0);
        check("rst_err", err_div0_o, 0);
        check("rst_a", alu_a_o, 0);
        check("rst_b", alu_b_o, 0);
        check("rst_sel", alu_sel_o, 0);
        check("rst_disp", disp_o, 8'h5A);

        // Table-driven operations.
        foreach (vecs[i]) begin
            do_clear();
            press(vecs[i].a);
            check($sformatf("v%0d_state_op", i), state_o, 1);
            check($sformatf("v%0d_a", i), alu_a_o, vecs[i].a);
            sw_i = {4'hC, vecs[i].op};
            #1;
            check($sformatf("v%0d_disp_op", i), disp_o, {4'h0, vecs[i].op});
            if (vecs[i].unary) begin
                sb.push_back('{vecs[i].exp_y, vecs[i].exp_err});
                press({4'h0, vecs[i].op});
                check($sformatf("v%0d_b_zero", i), alu_b_o, 0);
            end else begin
                press({4'h0, vecs[i].op});
                check($sformatf("v%0d_state_b", i), state_o, 2);
                sb.push_back('{vecs[i].exp_y, vecs[i].exp_err});
                press(vecs[i].b);
            end
            check($sformatf("v%0d_sel", i), alu_sel_o, vecs[i].exp_sel);
            wait_and_score($sformatf("v%0d", i));
            check($sformatf("v%0d_disp_show", i), disp_o, vecs[i].exp_y);
        end

        // Unary op goes OP -> EXEC directly.
        do_clear();
        press(8'h81);
        sw_i = 8'h02; enter_i = 1'b1;
        @(negedge clk);
        check("unary_exec", state_o, 3);
        enter_i = 1'b0;
        @(negedge clk);
        check("unary_show", state_o, 4);
        check("unary_result", result_o, 8'h02);

        // Divide by zero, then the press in SHOW clears the error.
        do_clear();
        press(8'h10); press(8'h0B); press(8'h00);
        check("div0_err", err_div0_o, 1);
        check("div0_result", result_o, 0);
        press(8'h99);
        check("div0_clr_err", err_div0_o, 0);
        check("div0_clr_state", state_o, 1);

        // Latency of a binary op, then chaining.
        do_clear();
        press(8'h05); press(8'h08);
        sw_i = 8'h03; enter_i = 1'b1;
        @(negedge clk);
        check("lat_exec", state_o, 3);
        check("lat_valid_early", result_valid_o, 0);
        @(negedge clk);
        enter_i = 1'b0;
        check("lat_show", state_o, 4);
        check("lat_valid", result_valid_o, 1);
        check("lat_result", result_o, 8'h08);
        @(negedge clk);
        check("held_exec_show", state_o, 4);
        press(8'hEE);
        check("chain_state", state_o, 1);
        check("chain_a", alu_a_o, 8'h08);
        check("chain_valid", result_valid_o, 0);
        check("chain_hold", result_o, 8'h08);
        press(8'h0A); press(8'h03);
        check("chain_result", result_o, 8'h18);
        press(8'h00); press(8'h02);
        check("chain_unary_b", alu_b_o, 0);
        check("chain_unary_res", result_o, 8'h30);

        // Held enter gives exactly one step.
        do_clear();
        sw_i = 8'h42; enter_i = 1'b1;
        repeat (20) @(negedge clk);
        enter_i = 1'b0;
        @(negedge clk);
        check("held_state", state_o, 1);
        check("held_a", alu_a_o, 8'h42);

        // Clear wins over a press in S_B.
        do_clear();
        press(8'h55); press(8'h08);
        check("clr_pre_state", state_o, 2);
        sw_i = 8'h77; enter_i = 1'b1; clear_i = 1'b1;
        @(negedge clk);
        check("clr_state", state_o, 0);
        check("clr_a", alu_a_o, 0);
        check("clr_b", alu_b_o, 0);
        check("clr_sel", alu_sel_o, 0);
        check("clr_result", result_o, 0);
        check("clr_valid", result_valid_o, 0);
        clear_i = 1'b0; enter_i = 1'b0;
        @(negedge clk);

        // Enter already high when reset releases counts as a press.
        rst = 1'b1; enter_i = 1'b1; sw_i = 8'h21;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_enter_state", state_o, 1);
        check("rst_enter_a", alu_a_o, 8'h21);
        enter_i = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
